ccff_bitstream_loader: RTL

Configuration-chain loader. It accepts a word-wide bitstream over a valid/ready stream and serialises it, one bit per shift, into the `ccff_head` of a tile configuration chain. It drives the chain's `config_enable` only on shift cycles, and counts the ones that leave through `ccff_tail`. The block sits directly upstream of the connection/switch-block configuration chains and runs on `prog_clk`.

---
 rtl/ccff_bitstream_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises a valid/ready word stream, LSB first,
// into ccff_head with a matching config_enable, and counts ones leaving ccff_tail.
module ccff_bitstream_loader #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 36,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              config_enable,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tail_ones
);

    localparam int unsigned      N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WORD  = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_CHAIN = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_WORDS = CNT_W'(N_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic [WORD_W-1:0] sreg_q,       sreg_d;
    logic [CNT_W-1:0]  cur_bits_q,   cur_bits_d;
    logic [CNT_W-1:0]  bits_left_q,  bits_left_d;
    logic [CNT_W-1:0]  words_left_q, words_left_d;
    logic [CNT_W-1:0]  tail_ones_q,  tail_ones_d;
    logic              head_q,       head_d;
    logic              cfg_en_q,     cfg_en_d;
    logic              done_q,       done_d;

    logic              ready_c;
    logic              shift_go;
    logic              accept;
    logic [CNT_W-1:0]  avail;
    logic [CNT_W-1:0]  new_bits;

    always_comb begin
        ready_c  = (state_q == ST_LOAD) && (cur_bits_q <= CNT_ONE)
                   && (words_left_q != '0) && !abort;
        shift_go = (state_q == ST_LOAD) && (cur_bits_q != '0) && !abort;
        accept   = ready_c && s_valid;
        // Bits still owed to the chain once the pending bit (if any) is issued.
        avail    = bits_left_q - cur_bits_q;
        new_bits = (avail < CNT_WORD) ? avail : CNT_WORD;
    end

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        cur_bits_d   = cur_bits_q;
        bits_left_d  = bits_left_q;
        words_left_d = words_left_q;
        head_d       = head_q;
        cfg_en_d     = 1'b0;
        done_d       = 1'b0;
        tail_ones_d  = tail_ones_q;

        // The chain shifts on every edge where the registered enable is high.
        if (cfg_en_q && ccff_tail) begin
            tail_ones_d = tail_ones_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    tail_ones_d  = '0;
                    bits_left_d  = CNT_CHAIN;
                    words_left_d = CNT_WORDS;
                    cur_bits_d   = '0;
                    sreg_d       = '0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (shift_go) begin
                        head_d      = sreg_q[0];
                        cfg_en_d    = 1'b1;
                        sreg_d      = sreg_q >> 1;
                        cur_bits_d  = cur_bits_q - CNT_ONE;
                        bits_left_d = bits_left_q - CNT_ONE;
                        if (bits_left_q == CNT_ONE) begin
                            state_d = ST_FIN;
                        end
                    end
                    // A load on the same edge as the last bit's shift overrides
                    // the shifted register, so words stream without a bubble.
                    if (accept) begin
                        sreg_d       = s_data;
                        cur_bits_d   = new_bits;
                        words_left_d = words_left_q - CNT_ONE;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                done_d  = !abort;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q      <= ST_IDLE;
            sreg_q       <= '0;
            cur_bits_q   <= '0;
            bits_left_q  <= '0;
            words_left_q <= '0;
            tail_ones_q  <= '0;
            head_q       <= 1'b0;
            cfg_en_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cur_bits_q   <= cur_bits_d;
            bits_left_q  <= bits_left_d;
            words_left_q <= words_left_d;
            tail_ones_q  <= tail_ones_d;
            head_q       <= head_d;
            cfg_en_q     <= cfg_en_d;
            done_q       <= done_d;
        end
    end

    assign s_ready       = ready_c;
    assign ccff_head     = head_q;
    assign config_enable = cfg_en_q;
    assign busy          = (state_q == ST_LOAD);
    assign done          = done_q;
    assign tail_ones     = tail_ones_q;

endmodule
